// File: rtl/sprite_link_pkg.sv
// Shared types for the SPI sprite link: command codes, the draw record and the command FSM states.
// Every other file of the link imports this package.
package sprite_link_pkg;

  localparam logic [7:0] CMD_DRAW  = 8'h01;
  localparam logic [7:0] CMD_PIXEL = 8'h02;
  localparam logic [7:0] CMD_CLEAR = 8'h03;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } draw_rec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DRAW,
    ST_PIXSEL,
    ST_PIXDATA,
    ST_IGNORE
  } link_state_t;

  // Queue occupancy as it is reported in the 5-bit status field.
  function automatic logic [4:0] sat_count5(input int unsigned c);
    return (c > 31) ? 5'd31 : 5'(c);
  endfunction

endpackage

// File: rtl/sprite_fifo.sv
// Generic record FIFO. Head is the oldest entry; it is visible the cycle after the push and reads 0 when empty.
// A push to a full queue is accepted only when it pops in the same cycle, and flush overrides push and pop.
module sprite_fifo
  import sprite_link_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type rec_t = draw_rec_t
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  rec_t                     push_data,
  input  logic                     pop,
  input  logic                     flush,
  output rec_t                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rec_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_sprite_link.sv
// SPI mode-0 slave in the FPGA clock domain: framed commands feed the sprite-store write port and a draw queue.
// Optional feature macro SPI_LINK_STATUS_EN: queue status is shifted out on spi_miso during the command byte.
module spi_sprite_link
  import sprite_link_pkg::*;
#(
  parameter  int SPRITE_NUM    = 16,
  parameter  int SPRITE_ADDR_W = 12,
  parameter  int QUEUE_DEPTH   = 16,
  localparam int SEL_W         = (SPRITE_NUM > 1) ? $clog2(SPRITE_NUM) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     spi_clk,
  input  logic                     spi_mosi,
  input  logic                     spi_cs,
  output logic                     spi_miso,
  output logic [SEL_W-1:0]         sprite_select,
  output logic                     sprite_w_en,
  output logic [SPRITE_ADDR_W-1:0] sprite_w_addr,
  output logic [7:0]               sprite_w_data,
  input  logic                     dequeue,
  output logic                     is_empty,
  output logic                     is_full,
  output logic                     overflow,
  output logic [7:0]               sprite_id,
  output logic [15:0]              sprite_x,
  output logic [15:0]              sprite_y,
  output logic [7:0]               sprite_scale
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [2:0] sck_sync;
  logic [1:0] mosi_sync;
  logic [2:0] cs_sync;
  logic       sck_rise;
  logic       cs_high;
  logic       cs_fall;

  // CS synchroniser resets to "selected" so a frame already in progress never looks like a new start.
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
    end else begin
      sck_sync  <= {sck_sync[1:0], spi_clk};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      cs_sync   <= {cs_sync[1:0], spi_cs};
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign cs_high  = cs_sync[1];
  assign cs_fall  = ~cs_sync[1] & cs_sync[2];

  logic [6:0] shreg;
  logic [7:0] rx_byte;
  logic [2:0] bit_cnt;
  logic       byte_valid;

  always_ff @(posedge clock) begin
    if (reset || cs_high) begin
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (sck_rise) begin
        shreg   <= {shreg[5:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          rx_byte    <= {shreg, mosi_sync[1]};
        end
      end
    end
  end

  link_state_t state;
  link_state_t state_nx;
  logic        take_cmd;
  logic        take_clear;
  logic        take_draw;
  logic        take_sel;
  logic        take_pix;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cs_high) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:   if (cs_fall) state_nx = ST_CMD;
        ST_CMD: begin
          if (byte_valid) begin
            unique case (rx_byte)
              CMD_DRAW:  state_nx = ST_DRAW;
              CMD_PIXEL: state_nx = ST_PIXSEL;
              default:   state_nx = ST_IGNORE;
            endcase
          end
        end
        ST_PIXSEL: if (byte_valid) state_nx = ST_PIXDATA;
        default:   state_nx = state;
      endcase
    end
  end

  always_comb begin
    take_cmd   = 1'b0;
    take_clear = 1'b0;
    take_draw  = 1'b0;
    take_sel   = 1'b0;
    take_pix   = 1'b0;
    if (byte_valid && !cs_high) begin
      unique case (state)
        ST_CMD: begin
          take_cmd   = 1'b1;
          take_clear = (rx_byte == CMD_CLEAR);
        end
        ST_DRAW:    take_draw = 1'b1;
        ST_PIXSEL:  take_sel  = 1'b1;
        ST_PIXDATA: take_pix  = 1'b1;
        default:    ;
      endcase
    end
  end

  logic [2:0]               draw_idx;
  draw_rec_t                rec_buf;
  logic                     push_req;
  logic [SPRITE_ADDR_W-1:0] pix_addr;
  draw_rec_t                head;
  logic [CW-1:0]            fifo_count;
  logic                     fifo_empty;
  logic                     fifo_full;

  // The drop decision is made in the cycle the record reaches the queue, against that cycle's dequeue.
  always_ff @(posedge clock) begin
    if (reset) begin
      draw_idx      <= '0;
      rec_buf       <= '0;
      push_req      <= 1'b0;
      overflow      <= 1'b0;
      sprite_select <= '0;
      pix_addr      <= '0;
      sprite_w_en   <= 1'b0;
      sprite_w_addr <= '0;
      sprite_w_data <= '0;
    end else begin
      push_req    <= 1'b0;
      sprite_w_en <= 1'b0;
      if (state != ST_DRAW) draw_idx <= '0;
      if (take_draw) begin
        unique case (draw_idx)
          3'd0:    rec_buf.id       <= rx_byte;
          3'd1:    rec_buf.x[15:8]  <= rx_byte;
          3'd2:    rec_buf.x[7:0]   <= rx_byte;
          3'd3:    rec_buf.y[15:8]  <= rx_byte;
          3'd4:    rec_buf.y[7:0]   <= rx_byte;
          default: rec_buf.scale    <= rx_byte;
        endcase
        push_req <= (draw_idx == 3'd5);
        draw_idx <= (draw_idx == 3'd5) ? 3'd0 : draw_idx + 3'd1;
      end
      if (take_clear)
        overflow <= 1'b0;
      else if (push_req && (fifo_count == CW'(QUEUE_DEPTH)) && !dequeue)
        overflow <= 1'b1;
      if (take_sel) begin
        sprite_select <= rx_byte[SEL_W-1:0];
        pix_addr      <= '0;
      end
      if (take_pix) begin
        sprite_w_en   <= 1'b1;
        sprite_w_addr <= pix_addr;
        sprite_w_data <= rx_byte;
        pix_addr      <= pix_addr + 1'b1;
      end
    end
  end

  sprite_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .rec_t (draw_rec_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req),
    .push_data (rec_buf),
    .pop       (dequeue),
    .flush     (take_clear),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign is_empty     = fifo_empty;
  assign is_full      = fifo_full;
  assign sprite_id    = head.id;
  assign sprite_x     = head.x;
  assign sprite_y     = head.y;
  assign sprite_scale = head.scale;

`ifdef SPI_LINK_STATUS_EN
  logic [7:0] status_sr;
  logic       status_active;
  logic       sck_fall;

  assign sck_fall = ~sck_sync[1] & sck_sync[2];

  always_ff @(posedge clock) begin
    if (reset) begin
      status_sr     <= '0;
      status_active <= 1'b0;
    end else if (cs_high) begin
      status_active <= 1'b0;
    end else if (cs_fall) begin
      status_sr     <= {overflow, fifo_full, fifo_empty, sat_count5(int'(fifo_count))};
      status_active <= 1'b1;
    end else if (status_active) begin
      if (take_cmd)      status_active <= 1'b0;
      else if (sck_fall) status_sr     <= {status_sr[6:0], 1'b0};
    end
  end

  assign spi_miso = status_active & status_sr[7];
`else
  assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sprite_link.sv
// Directed bench for spi_sprite_link: drives SPI frames on the pins and checks queue, pixel port and status.
// A second instance with a 2-bit address and depth-2 queue shares the pins to exercise address wrap.
module tb_spi_sprite_link;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs = 1'b1;
  logic        dequeue = 1'b0;
  logic        s_dequeue = 1'b0;

  logic        spi_miso;
  logic [3:0]  sprite_select;
  logic        sprite_w_en;
  logic [11:0] sprite_w_addr;
  logic [7:0]  sprite_w_data;
  logic        is_empty, is_full, overflow;
  logic [7:0]  sprite_id, sprite_scale;
  logic [15:0] sprite_x, sprite_y;

  logic        s_miso;
  logic [3:0]  s_select;
  logic        s_w_en;
  logic [1:0]  s_w_addr;
  logic [7:0]  s_w_data;
  logic        s_empty, s_full, s_overflow;
  logic [7:0]  s_id, s_scale;
  logic [15:0] s_x, s_y;

`ifdef SPI_LINK_STATUS_EN
  localparam logic [7:0] EXP_STATUS = 8'b0000_0010;
`else
  localparam logic [7:0] EXP_STATUS = 8'h00;
`endif

  always #5 clock = ~clock;

  spi_sprite_link u_dut (
    .clock(clock), .reset(reset), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_miso(spi_miso), .sprite_select(sprite_select), .sprite_w_en(sprite_w_en),
    .sprite_w_addr(sprite_w_addr), .sprite_w_data(sprite_w_data), .dequeue(dequeue),
    .is_empty(is_empty), .is_full(is_full), .overflow(overflow), .sprite_id(sprite_id),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_scale(sprite_scale)
  );

  spi_sprite_link #(.SPRITE_ADDR_W(2), .QUEUE_DEPTH(2)) u_small (
    .clock(clock), .reset(reset), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_miso(s_miso), .sprite_select(s_select), .sprite_w_en(s_w_en),
    .sprite_w_addr(s_w_addr), .sprite_w_data(s_w_data), .dequeue(s_dequeue),
    .is_empty(s_empty), .is_full(s_full), .overflow(s_overflow), .sprite_id(s_id),
    .sprite_x(s_x), .sprite_y(s_y), .sprite_scale(s_scale)
  );

  int          vec = 0;
  int          errs = 0;
  logic [7:0]  fb[$];
  bit          deq_on_last = 1'b0;
  logic [7:0]  miso_byte;
  logic [7:0]  miso_first;
  logic [11:0] wa_q[$];
  logic [7:0]  wd_q[$];
  logic [1:0]  s_wa_q[$];

  always @(negedge clock) begin
    if (sprite_w_en) begin
      wa_q.push_back(sprite_w_addr);
      wd_q.push_back(sprite_w_data);
    end
    if (s_w_en) s_wa_q.push_back(s_w_addr);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit deq);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clock);
      spi_mosi = b[i];
      spi_clk  = 1'b0;
      repeat (4) @(negedge clock);
      miso_byte[i] = spi_miso;
      spi_clk = 1'b1;
      repeat (4) @(negedge clock);
      if (deq && i == 0) begin
        dequeue = 1'b1;
        @(negedge clock);
        dequeue = 1'b0;
      end
    end
  endtask

  task automatic start_frame();
    @(negedge clock);
    spi_cs = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic end_frame();
    @(negedge clock);
    spi_clk = 1'b0;
    repeat (4) @(negedge clock);
    spi_cs = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic run_frame();
    start_frame();
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i], deq_on_last && (i == fb.size() - 1));
      if (i == 0) miso_first = miso_byte;
    end
    end_frame();
  endtask

  task automatic pop_one();
    @(negedge clock);
    dequeue = 1'b1;
    @(negedge clock);
    dequeue = 1'b0;
  endtask

  task automatic add_rec(input int i);
    fb.push_back(8'(8'h20 + i));
    fb.push_back(8'h01);
    fb.push_back(8'(i));
    fb.push_back(8'h02);
    fb.push_back(8'(i));
    fb.push_back(8'(8'h30 + i));
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    s_wa_q.delete();
  endtask

  initial begin
    // reset defaults
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("rst_empty", is_empty, 1);
    chk("rst_full", is_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_head", {sprite_id, sprite_x, sprite_y, sprite_scale}, 0);
    chk("rst_miso", spi_miso, 0);
    chk("rst_sel", sprite_select, 0);

    // single draw record
    fb = '{8'h01, 8'h05, 8'h01, 8'h2C, 8'h00, 8'hF0, 8'h80};
    run_frame();
    chk("draw_id", sprite_id, 8'd5);
    chk("draw_x", sprite_x, 16'd300);
    chk("draw_y", sprite_y, 16'd240);
    chk("draw_scale", sprite_scale, 8'd128);
    chk("draw_empty", is_empty, 0);
    chk("draw_no_wen", wa_q.size(), 0);
    pop_one();
    chk("deq_empty", is_empty, 1);
    chk("deq_head", sprite_id, 0);
    pop_one();
    chk("deq_on_empty", is_empty, 1);

    // pixel writes
    fb = '{8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    run_frame();
    chk("pix_sel", sprite_select, 4'd3);
    chk("pix_cnt", wa_q.size(), 3);
    chk("pix_a0", wa_q[0], 0);
    chk("pix_a2", wa_q[2], 2);
    chk("pix_d0", wd_q[0], 8'hAA);
    chk("pix_d1", wd_q[1], 8'hBB);
    chk("pix_d2", wd_q[2], 8'hCC);
    clear_mon();
    fb = '{8'h02, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_frame();
    chk("pix2_sel", sprite_select, 4'd1);
    chk("pix2_last_addr", wa_q[4], 12'd4);
    chk("pix2_last_data", wd_q[4], 8'h55);
    chk("wrap_cnt", s_wa_q.size(), 5);
    chk("wrap_a3", s_wa_q[3], 2'd3);
    chk("wrap_a4", s_wa_q[4], 2'd0);
    clear_mon();

    // aborted record, then a complete one, then an unknown command
    fb = '{8'h01, 8'h07, 8'h00};
    run_frame();
    chk("abort_empty", is_empty, 1);
    fb = '{8'h01, 8'h09, 8'h00, 8'h0A, 8'h00, 8'h0B, 8'h0C};
    run_frame();
    chk("after_abort_head", {sprite_id, sprite_x, sprite_y, sprite_scale}, 48'h09_000A_000B_0C);
    fb = '{8'h7F, 8'h01, 8'h02, 8'h03};
    run_frame();
    chk("unk_head", sprite_id, 8'h09);
    chk("unk_no_wen", wa_q.size(), 0);
    pop_one();
    chk("unk_no_push", is_empty, 1);

    // status readback with two queued records
    fb = '{8'h01};
    add_rec(1);
    add_rec(2);
    run_frame();
    fb = '{8'h7F, 8'h55};
    run_frame();
    chk("status_cmd", miso_first, EXP_STATUS);
    chk("status_data", miso_byte, 0);
    chk("status_head", sprite_id, 8'h21);
    pop_one();
    chk("status_head2", sprite_id, 8'h22);
    pop_one();
    chk("status_drain", is_empty, 1);

    // fill to depth, concurrent push/pop while full, then overflow
    fb = '{8'h01};
    for (int i = 0; i < 16; i++) add_rec(i);
    run_frame();
    chk("fill_full", is_full, 1);
    chk("fill_ovf", overflow, 0);
    chk("fill_head", sprite_id, 8'h20);
    fb = '{8'h01};
    add_rec(16);
    deq_on_last = 1'b1;
    run_frame();
    deq_on_last = 1'b0;
    chk("pp_full", is_full, 1);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", sprite_id, 8'h21);
    fb = '{8'h01};
    add_rec(17);
    run_frame();
    chk("ovf_full", is_full, 1);
    chk("ovf_set", overflow, 1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("order_id%0d", k), sprite_id, 8'(8'h21 + k));
      chk($sformatf("order_x%0d", k), sprite_x, 16'(16'h0101 + k));
      pop_one();
    end
    chk("drained_empty", is_empty, 1);
    chk("ovf_sticky", overflow, 1);
    fb = '{8'h01};
    add_rec(0);
    add_rec(1);
    run_frame();
    fb = '{8'h03};
    run_frame();
    chk("clear_empty", is_empty, 1);
    chk("clear_ovf", overflow, 0);
    chk("clear_full", is_full, 0);

    // reset in the middle of a pixel frame
    clear_mon();
    start_frame();
    send_byte(8'h02, 1'b0);
    send_byte(8'h05, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    end_frame();
    chk("midrst_no_wen", wa_q.size(), 0);
    chk("midrst_sel", sprite_select, 0);
    fb = '{8'h02, 8'h06, 8'h77};
    run_frame();
    chk("recover_sel", sprite_select, 4'd6);
    chk("recover_wen", wa_q.size(), 1);
    chk("recover_data", wd_q[0], 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
